// File: rtl/e06_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 4-input/3-output combinational block.
// Walks codes 0..15, settles, samples f/g/h into truth-table maps and scores them.
module e06_sweep_ctrl #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] EXP_F         = 16'h0000,
    parameter logic [15:0] EXP_G         = 16'h0000,
    parameter logic [15:0] EXP_H         = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        step_mode,
    input  logic        step,
    input  logic        f_in,
    input  logic        g_in,
    input  logic        h_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err,
    output logic [15:0] f_map,
    output logic [15:0] g_map,
    output logic [15:0] h_map
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD,
        FINISH
    } state_t;

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] code;
    logic [7:0] settle_cnt;
    logic       start_sweep;
    logic       sample_now;
    logic       advance;
    logic       aborting;
    logic       mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks every other transition, including a simultaneous start in IDLE.
    always_comb begin
        state_next  = state;
        start_sweep = 1'b0;
        sample_now  = 1'b0;
        advance     = 1'b0;
        aborting    = 1'b0;
        if (abort && state != IDLE) begin
            aborting   = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        start_sweep = 1'b1;
                        state_next  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state_next = SAMPLE;
                    end
                end
                SAMPLE: begin
                    sample_now = 1'b1;
                    if (code == 4'd15) begin
                        state_next = FINISH;
                    end else if (step_mode) begin
                        state_next = HOLD;
                    end else begin
                        advance    = 1'b1;
                        state_next = SETTLE;
                    end
                end
                HOLD: begin
                    if (step || !step_mode) begin
                        advance    = 1'b1;
                        state_next = SETTLE;
                    end
                end
                FINISH: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign mismatch = (f_in != EXP_F[code]) || (g_in != EXP_G[code]) || (h_in != EXP_H[code]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= 4'd0;
            settle_cnt <= 8'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 5'd0;
            first_err  <= 4'd0;
            f_map      <= 16'h0000;
            g_map      <= 16'h0000;
            h_map      <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (aborting) begin
                pass <= 1'b0;
            end else if (start_sweep) begin
                code       <= 4'd0;
                settle_cnt <= SETTLE_RELOAD;
                pass       <= 1'b0;
                err_count  <= 5'd0;
                first_err  <= 4'd0;
                f_map      <= 16'h0000;
                g_map      <= 16'h0000;
                h_map      <= 16'h0000;
            end else begin
                if (state == SETTLE && settle_cnt != 8'd0) begin
                    settle_cnt <= settle_cnt - 8'd1;
                end
                if (sample_now) begin
                    f_map[code] <= f_in;
                    g_map[code] <= g_in;
                    h_map[code] <= h_in;
                    if (mismatch) begin
                        err_count <= err_count + 5'd1;
                        if (err_count == 5'd0) begin
                            first_err <= code;
                        end
                    end
                end
                if (advance) begin
                    code       <= code + 4'd1;
                    settle_cnt <= SETTLE_RELOAD;
                end
                // err_count already holds the code-15 result by the time FINISH is reached.
                if (state == FINISH) begin
                    done <= 1'b1;
                    pass <= (err_count == 5'd0);
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign a    = code[3];
    assign b    = code[2];
    assign c    = code[1];
    assign d    = code[0];

endmodule

// File: doc/e06_sweep_ctrl.md
Name: e06_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 4-input/3-output combinational block (inputs a,b,c,d; outputs f,g,h) in hardware. On request it walks all 16 input codes and waits a programmable settle time per code. It then samples f/g/h into per-output 16-bit truth-table maps and compares them against parameterised expected maps. It sits between the combinational block and a board-level start button/LED status.

Parameters:
SETTLE_CYCLES, 1, clock cycles each code is held before sampling; legal range 1..255.
EXP_F, 16'h0000, expected f truth table; bit k = f for code k.
EXP_G, 16'h0000, expected g truth table.
EXP_H, 16'h0000, expected h truth table.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
abort  input  1  terminate the sweep; return to IDLE on the next edge
step_mode  input  1  1 = pause after each sample until step
step  input  1  one-cycle advance pulse while paused
f_in  input  1  f from the combinational block
g_in  input  1  g from the combinational block
h_in  input  1  h from the combinational block
a  output  1  code bit 3 (MSB), registered
b  output  1  code bit 2, registered
c  output  1  code bit 1, registered
d  output  1  code bit 0 (LSB), registered
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the sweep completes (not on abort)
pass  output  1  1 if the last completed sweep matched all expected maps; held until the next start
err_count  output  5  number of codes with any mismatch, 0..16
first_err  output  4  lowest mismatching code; 0 if none
f_map  output  16  captured f per code
g_map  output  16  captured g per code
h_map  output  16  captured h per code

Behaviour:
- Reset (async, immediate): state=IDLE, code=0, a..d=0, busy=0, done=0, pass=0, err_count=0, first_err=0, all maps=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, HOLD, FINISH.
- IDLE, start=1: code<=0, a..d<=0, maps<=0, err_count<=0, first_err<=0, pass<=0, counter<=SETTLE_CYCLES-1, go SETTLE. If start and abort are both high, abort wins and the block stays in IDLE.
- SETTLE: when counter=0, go SAMPLE; otherwise decrement.
- SAMPLE (one cycle):
  - Capture f_map[code]<=f_in, g_map[code]<=g_in, h_map[code]<=h_in.
  - Mismatch = any in-bit differs from EXP_x[code]. On mismatch: err_count+1; if err_count was 0, first_err<=code.
  - If code=15: go FINISH.
  - Else if step_mode: go HOLD.
  - Else: code+1, drive new a..d, reload counter, go SETTLE.
- HOLD: wait for step=1, then advance exactly as SAMPLE's non-final branch. If step_mode drops to 0 while in HOLD, advance on the next edge without step.
- FINISH (one cycle): done=1; pass<=(err_count==0), using the final updated count. Go IDLE.
- Timing, step_mode=0: a..d change on the edge entering SETTLE; the sample occurs SETTLE_CYCLES+1 cycles after that edge. The full sweep is 16*(SETTLE_CYCLES+1)+1 cycles from start to the done pulse.
- code is 4 bits; it never wraps, because the sweep ends at code 15.
- abort in any non-IDLE state: go IDLE next edge, busy=0, done not pulsed, pass=0. Partial maps and err_count are retained until the next start.
- start outside IDLE: ignored.
- step outside HOLD: ignored.
- Reset mid-sweep: all values return to reset state immediately, with no done pulse.

Test Plan:
- Golden match: EXP_F=16'hA5A5, EXP_G=16'h0FF0, EXP_H=16'h8001, DUT model matching, SETTLE_CYCLES=1, pulse start -> done after 33 cycles; pass=1, err_count=0, f_map=16'hA5A5, g_map=16'h0FF0, h_map=16'h8001.
- Drive ordering: record a..d at each SAMPLE -> sequence {a,b,c,d}=0000,0001,…,1111, with a as the MSB.
- Injected faults: model inverts g at codes 5 and 12 -> pass=0, err_count=2, first_err=5, g_map=16'h0FF0^16'h1020.
- Settle timing: SETTLE_CYCLES=3 with a model that has 2-cycle output latency -> pass=1 and done at cycle 65. With SETTLE_CYCLES=1 and the same model -> pass=0.
- Step mode: step_mode=1, no step for 10 cycles after the first SAMPLE -> code stays 0, busy=1. 15 step pulses -> done, with identical maps.
- Abort/reset: abort at code 7 -> busy=0, no done pulse, pass=0; a new start completes normally. rst asserted mid-sweep -> all outputs 0 immediately.
